// File: rtl/pipeline_hazard_tracker.sv
// Producer-side hazard tracker. It follows the writers held in EX, MEM and WB, and stalls
// the front end on load-use hazards and on outstanding loads, inserting NOP bubbles.
module pipeline_hazard_tracker #(
  parameter int         REG_INDEX_BIT_WIDTH = 4,
  parameter logic [3:0] LW_OPCODE           = 4'b0100,
  parameter logic [3:0] NOP_OPCODE          = 4'b0000,
  parameter int         MAX_WAIT            = 15
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           id_valid,
  input  logic [3:0]                     id_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_dest,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2,
  input  logic                           id_src1_used,
  input  logic                           id_src2_used,
  input  logic                           mem_ready,
  output logic                           stall,
  output logic [3:0]                     ex_opcode,
  output logic [3:0]                     mem_opcode,
  output logic [3:0]                     wb_opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] ex_index,
  output logic [REG_INDEX_BIT_WIDTH-1:0] mem_index,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_index,
  output logic                           wait_timeout
);

  localparam int NUM_STAGES = 3;
  localparam int S_EX       = 0;
  localparam int S_MEM      = 1;
  localparam int S_WB       = 2;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t                           state_reg, state_next;
  logic [CNT_W-1:0]                 cnt_reg, cnt_next;
  logic                             timeout_reg, timeout_next;

  logic [3:0]                       stage_op  [NUM_STAGES];
  logic [REG_INDEX_BIT_WIDTH-1:0]   stage_idx [NUM_STAGES];
  logic [3:0]                       op_next   [NUM_STAGES];
  logic [REG_INDEX_BIT_WIDTH-1:0]   idx_next  [NUM_STAGES];

  logic                             src1_hit;
  logic                             src2_hit;
  logic                             load_use;
  logic                             mem_busy;
  logic [3:0]                       ex_fill_op;
  logic [REG_INDEX_BIT_WIDTH-1:0]   ex_fill_idx;

  // One register pair per stage; the comb block decides what each stage loads.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic [3:0]                     op_reg;
    logic [REG_INDEX_BIT_WIDTH-1:0] idx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        op_reg  <= NOP_OPCODE;
        idx_reg <= '0;
      end else begin
        op_reg  <= op_next[gi];
        idx_reg <= idx_next[gi];
      end
    end

    assign stage_op[gi]  = op_reg;
    assign stage_idx[gi] = idx_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  assign src1_hit = id_src1_used && (id_src1 == stage_idx[S_EX]);
  assign src2_hit = id_src2_used && (id_src2 == stage_idx[S_EX]);
  assign load_use = (stage_op[S_EX] == LW_OPCODE) && (stage_idx[S_EX] != '0) &&
                    id_valid && (src1_hit || src2_hit);
  assign mem_busy = (stage_op[S_MEM] == LW_OPCODE) && !mem_ready;

  assign ex_fill_op  = (id_valid && !load_use) ? id_opcode : NOP_OPCODE;
  assign ex_fill_idx = (id_valid && !load_use) ? id_dest   : '0;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    stall        = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      op_next[i]  = stage_op[i];
      idx_next[i] = stage_idx[i];
    end

    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          stall          = 1'b1;
          op_next[S_WB]  = NOP_OPCODE;
          idx_next[S_WB] = '0;
          state_next     = MEM_WAIT;
          cnt_next       = CNT_ONE;
        end else begin
          stall           = load_use;
          op_next[S_WB]   = stage_op[S_MEM];
          idx_next[S_WB]  = stage_idx[S_MEM];
          op_next[S_MEM]  = stage_op[S_EX];
          idx_next[S_MEM] = stage_idx[S_EX];
          op_next[S_EX]   = ex_fill_op;
          idx_next[S_EX]  = ex_fill_idx;
        end
      end

      MEM_WAIT: begin
        // The release cycle still stalls even though the pipeline advances.
        stall = 1'b1;
        if (mem_ready) begin
          op_next[S_WB]   = stage_op[S_MEM];
          idx_next[S_WB]  = stage_idx[S_MEM];
          op_next[S_MEM]  = stage_op[S_EX];
          idx_next[S_MEM] = stage_idx[S_EX];
          op_next[S_EX]   = ex_fill_op;
          idx_next[S_EX]  = ex_fill_idx;
          state_next      = RUN;
          cnt_next        = '0;
        end else begin
          op_next[S_WB]  = NOP_OPCODE;
          idx_next[S_WB] = '0;
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    if (cnt_next == CNT_MAX) begin
      timeout_next = 1'b1;
    end
  end

  assign ex_opcode    = stage_op[S_EX];
  assign mem_opcode   = stage_op[S_MEM];
  assign wb_opcode    = stage_op[S_WB];
  assign ex_index     = stage_idx[S_EX];
  assign mem_index    = stage_idx[S_MEM];
  assign wb_index     = stage_idx[S_WB];
  assign wait_timeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Bench for pipeline_hazard_tracker: a table of directed vectors, a timeout/async-reset
// sequence, and random stimulus checked against a queue-style reference model.
module tb_pipeline_hazard_tracker;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] LW  = 4'b0100;
  localparam logic [3:0] ADD = 4'b1100;
  localparam logic [3:0] SW  = 4'b0011;
  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_src1_used, id_src2_used, mem_ready;
  logic [3:0] id_opcode, id_dest, id_src1, id_src2;
  logic       stall, wait_timeout;
  logic [3:0] ex_opcode, mem_opcode, wb_opcode, ex_index, mem_index, wb_index;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       valid;
    logic [3:0] op;
    logic [3:0] dest;
    logic       s1u;
    logic [3:0] s1;
    logic       s2u;
    logic [3:0] s2;
    logic       rdy;
    logic       st;
    logic [3:0] eo, ei, mo, mi, wo, wi;
  } vec_t;

  vec_t vecs[$];

  // Reference model: stage contents as plain arrays (0=EX, 1=MEM, 2=WB).
  logic [3:0] m_op  [3];
  logic [3:0] m_idx [3];
  logic       m_waiting;
  int         m_cnt;
  logic       m_to;

  pipeline_hazard_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_dest      (id_dest),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .ex_opcode    (ex_opcode),
    .mem_opcode   (mem_opcode),
    .wb_opcode    (wb_opcode),
    .ex_index     (ex_index),
    .mem_index    (mem_index),
    .wb_index     (wb_index),
    .wait_timeout (wait_timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [3:0] op, input logic [3:0] dest,
                              input logic s1u, input logic [3:0] s1, input logic s2u,
                              input logic [3:0] s2, input logic rdy, input logic st,
                              input logic [3:0] eo, input logic [3:0] ei,
                              input logic [3:0] mo, input logic [3:0] mi,
                              input logic [3:0] wo, input logic [3:0] wi);
    vec_t v;
    v.valid = valid; v.op = op; v.dest = dest; v.s1u = s1u; v.s1 = s1;
    v.s2u = s2u; v.s2 = s2; v.rdy = rdy; v.st = st;
    v.eo = eo; v.ei = ei; v.mo = mo; v.mi = mi; v.wo = wo; v.wi = wi;
    return v;
  endfunction

  function automatic vec_t idle_v(input logic st, input logic [3:0] eo, input logic [3:0] ei,
                                  input logic [3:0] mo, input logic [3:0] mi,
                                  input logic [3:0] wo, input logic [3:0] wi);
    return mk(1'b0, NOP, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, st, eo, ei, mo, mi, wo, wi);
  endfunction

  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_opcode    = v.op;
    id_dest      = v.dest;
    id_src1_used = v.s1u;
    id_src1      = v.s1;
    id_src2_used = v.s2u;
    id_src2      = v.s2;
    mem_ready    = v.rdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] eo, input logic [3:0] ei,
                          input logic [3:0] mo, input logic [3:0] mi,
                          input logic [3:0] wo, input logic [3:0] wi, input logic to);
    chk({tag, " ex_opcode"},    32'(ex_opcode),    32'(eo));
    chk({tag, " ex_index"},     32'(ex_index),     32'(ei));
    chk({tag, " mem_opcode"},   32'(mem_opcode),   32'(mo));
    chk({tag, " mem_index"},    32'(mem_index),    32'(mi));
    chk({tag, " wb_opcode"},    32'(wb_opcode),    32'(wo));
    chk({tag, " wb_index"},     32'(wb_index),     32'(wi));
    chk({tag, " wait_timeout"}, 32'(wait_timeout), 32'(to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_op[i]  = NOP;
      m_idx[i] = 4'd0;
    end
    m_waiting = 1'b0;
    m_cnt     = 0;
    m_to      = 1'b0;
  endtask

  // An outstanding load freezes EX/MEM and drains WB; otherwise everything moves
  // one slot along, and ID enters EX unless it depends on a load sitting in EX.
  task automatic model_step(input vec_t v, output logic st);
    logic lu, busy;
    lu = v.valid && (m_op[0] == LW) && (m_idx[0] != 4'd0) &&
         ((v.s1u && (v.s1 == m_idx[0])) || (v.s2u && (v.s2 == m_idx[0])));
    busy = (m_op[1] == LW) && !v.rdy;
    if (busy) begin
      st       = 1'b1;
      m_op[2]  = NOP;
      m_idx[2] = 4'd0;
      if (m_cnt < MAX_WAIT) m_cnt++;
      if (m_cnt == MAX_WAIT) m_to = 1'b1;
    end else begin
      st       = lu || m_waiting;
      m_op[2]  = m_op[1];  m_idx[2] = m_idx[1];
      m_op[1]  = m_op[0];  m_idx[1] = m_idx[0];
      m_op[0]  = (v.valid && !lu) ? v.op   : NOP;
      m_idx[0] = (v.valid && !lu) ? v.dest : 4'd0;
      m_cnt    = 0;
    end
    m_waiting = busy;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    do_reset();

    chk("reset stall", 32'(stall), 32'd0);
    chk_regs("reset", NOP, 4'd0, NOP, 4'd0, NOP, 4'd0, 1'b0);

    // ADD dest 3 three times, then drain
    vecs.push_back(mk(1'b1, ADD, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, ADD, 4'd3, NOP, 4'd0, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, ADD, 4'd3, ADD, 4'd3, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, ADD, 4'd3, ADD, 4'd3, ADD, 4'd3));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, ADD, 4'd3, ADD, 4'd3));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, ADD, 4'd3));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    // LW dest 5 then a src1=5 consumer: one bubble
    vecs.push_back(mk(1'b1, LW,  4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, LW,  4'd5, NOP, 4'd0, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd6, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b1, NOP, 4'd0, LW,  4'd5, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd6, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, ADD, 4'd6, NOP, 4'd0, LW,  4'd5));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, ADD, 4'd6, NOP, 4'd0));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, ADD, 4'd6));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    // LW dest 0 then a consumer of register 0: no stall
    vecs.push_back(mk(1'b1, LW,  4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, LW,  4'd0, NOP, 4'd0, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd7, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, ADD, 4'd7, LW,  4'd0, NOP, 4'd0));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, ADD, 4'd7, LW,  4'd0));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, ADD, 4'd7));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    // LW dest 9 waits three cycles in MEM, then releases
    vecs.push_back(mk(1'b1, LW,  4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, LW,  4'd9, NOP, 4'd0, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd2, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, ADD, 4'd2, LW,  4'd9, NOP, 4'd0));
    vecs.push_back(mk(1'b1, SW,  4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, ADD, 4'd2, LW,  4'd9, NOP, 4'd0));
    vecs.push_back(mk(1'b1, SW,  4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, ADD, 4'd2, LW,  4'd9, NOP, 4'd0));
    vecs.push_back(mk(1'b1, SW,  4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, ADD, 4'd2, LW,  4'd9, NOP, 4'd0));
    vecs.push_back(mk(1'b1, SW,  4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, SW,  4'd4, ADD, 4'd2, LW,  4'd9));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, SW,  4'd4, ADD, 4'd2));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, SW,  4'd4));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    // LW waiting in MEM while LW in EX feeds an ID consumer: wait first, bubble once
    vecs.push_back(mk(1'b1, LW,  4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, LW,  4'd5, NOP, 4'd0, NOP, 4'd0));
    vecs.push_back(mk(1'b1, LW,  4'd6, 1'b0, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, LW,  4'd6, LW,  4'd5, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd7, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b1, LW,  4'd6, LW,  4'd5, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd7, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b1, LW,  4'd6, LW,  4'd5, NOP, 4'd0));
    vecs.push_back(mk(1'b1, ADD, 4'd7, 1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b1, NOP, 4'd0, LW,  4'd6, LW,  4'd5));
    vecs.push_back(mk(1'b1, ADD, 4'd7, 1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, ADD, 4'd7, NOP, 4'd0, LW,  4'd6));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, ADD, 4'd7, NOP, 4'd0));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, ADD, 4'd7));
    vecs.push_back(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].st));
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ei, vecs[i].mo, vecs[i].mi,
               vecs[i].wo, vecs[i].wi, 1'b0);
      $display("[TB] vec %0d op=%h dest=%0d rdy=%b stall=%b ex=%h/%0d mem=%h/%0d wb=%h/%0d",
               i, vecs[i].op, vecs[i].dest, vecs[i].rdy, vecs[i].st,
               ex_opcode, ex_index, mem_opcode, mem_index, wb_opcode, wb_index);
    end

    // Long memory wait: timeout rises at the MAX_WAIT-th wait cycle and sticks
    @(negedge clk);
    drive(mk(1'b1, LW, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    @(negedge clk);
    drive(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    @(posedge clk);
    #1;
    chk("wait setup mem_index", 32'(mem_index), 32'd8);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("wait%0d stall", k), 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("wait%0d wb_opcode", k), 32'(wb_opcode), 32'(NOP));
      chk($sformatf("wait%0d mem_index", k), 32'(mem_index), 32'd8);
      chk($sformatf("wait%0d wait_timeout", k), 32'(wait_timeout), 32'(k >= MAX_WAIT));
      $display("[TB] wait %0d stall=%b mem=%h/%0d wb=%h timeout=%b",
               k, stall, mem_opcode, mem_index, wb_opcode, wait_timeout);
    end

    // Reset mid-wait, away from any clock edge
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset stall", 32'(stall), 32'd0);
    chk_regs("async reset", NOP, 4'd0, NOP, 4'd0, NOP, 4'd0, 1'b0);
    $display("[TB] async reset applied mid-wait at %0t", $time);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0));
    @(posedge clk);
    #1;
    chk_regs("post reset", NOP, 4'd0, NOP, 4'd0, NOP, 4'd0, 1'b0);

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      vec_t r;
      logic est;
      @(negedge clk);
      r = idle_v(1'b0, NOP, 4'd0, NOP, 4'd0, NOP, 4'd0);
      r.valid = ($urandom_range(0, 9) < 8);
      r.op    = ($urandom_range(0, 9) < 4) ? LW : 4'($urandom_range(0, 15));
      r.dest  = 4'($urandom_range(0, 3));
      r.s1u   = ($urandom_range(0, 9) < 7);
      r.s1    = 4'($urandom_range(0, 3));
      r.s2u   = ($urandom_range(0, 9) < 5);
      r.s2    = 4'($urandom_range(0, 3));
      r.rdy   = ($urandom_range(0, 9) < 6);
      drive(r);
      model_step(r, est);
      #1;
      chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(est));
      @(posedge clk);
      #1;
      chk_regs($sformatf("rnd%0d", n), m_op[0], m_idx[0], m_op[1], m_idx[1],
               m_op[2], m_idx[2], m_to);
      $display("[TB] rnd %0d v=%b op=%h d=%0d rdy=%b stall=%b ex=%h/%0d mem=%h/%0d wb=%h/%0d",
               n, r.valid, r.op, r.dest, r.rdy, est,
               ex_opcode, ex_index, mem_opcode, mem_index, wb_opcode, wb_index);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
